// File: rtl/pacman_pkg.sv
// Shared encodings for the Pacman game logic: directions, controller states and
// the open-path mask bit order.
package pacman_pkg;

  localparam int unsigned DIR_W  = 2;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned NUM_BTNS = 5;

  typedef enum logic [DIR_W-1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // open_mask bit positions match the direction encoding
  localparam int unsigned MASK_UP    = 0;
  localparam int unsigned MASK_DOWN  = 1;
  localparam int unsigned MASK_LEFT  = 2;
  localparam int unsigned MASK_RIGHT = 3;

  // Button bit order inside the press vector: directions first, then center
  localparam int unsigned BTN_CENTER = 4;

  // Fixed priority up > down > left > right among simultaneous direction presses
  function automatic dir_e dir_from_press(input logic [3:0] press);
    if (press[MASK_UP])        return DIR_UP;
    else if (press[MASK_DOWN]) return DIR_DOWN;
    else if (press[MASK_LEFT]) return DIR_LEFT;
    else                       return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer plus rising-edge detector; flops reset high so a button
// held through reset release does not produce a press.
module btn_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/input_dir_ctrl.sv
// Pacman input controller: turns button presses into a pending turn request and
// commits it on a game step when the requested path is open.
module input_dir_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_TICKS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_center,
  input  logic              move_tick,
  input  logic [MASK_W-1:0] open_mask,
  output logic [DIR_W-1:0]  cur_dir,
  output logic              moving,
  output logic              pend_valid,
  output logic [DIR_W-1:0]  pend_dir,
  output logic [1:0]        state,
  output logic              dir_change
);

  localparam int unsigned CNT_W = $clog2(PEND_TICKS + 1);

  logic [NUM_BTNS-1:0] btn_vec;
  logic [NUM_BTNS-1:0] press_c;

  assign btn_vec = {btn_center, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_edge (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_vec[i]),
      .press_c (press_c[i])
    );
  end

  state_e           state_q, state_d;
  dir_e             cur_dir_q, cur_dir_d;
  dir_e             pend_dir_q, pend_dir_d;
  logic             moving_q, moving_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic             dir_change_q, dir_change_d;

  logic center_press_c;
  logic dir_press_c;
  dir_e dir_req_c;

  assign center_press_c = press_c[BTN_CENTER];
  assign dir_press_c    = |press_c[3:0];
  assign dir_req_c      = dir_from_press(press_c[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_dir_q    <= DIR_LEFT;
      moving_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_UP;
      pend_cnt_q   <= '0;
      dir_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      moving_q     <= moving_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      pend_cnt_q   <= pend_cnt_d;
      dir_change_q <= dir_change_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    moving_d     = moving_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    pend_cnt_d   = pend_cnt_q;
    dir_change_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (center_press_c) begin
          state_d = ST_RUN;
        end else if (dir_press_c) begin
          state_d      = ST_RUN;
          pend_valid_d = 1'b1;
          pend_dir_d   = dir_req_c;
          pend_cnt_d   = CNT_W'(PEND_TICKS);
        end
      end

      ST_RUN: begin
        if (center_press_c) begin
          state_d  = ST_PAUSE;
          moving_d = 1'b0;
        end else begin
          // The tick acts on the request registered before this cycle's press
          if (move_tick) begin
            if (pend_valid_q && open_mask[pend_dir_q]) begin
              cur_dir_d    = pend_dir_q;
              pend_valid_d = 1'b0;
              moving_d     = 1'b1;
              dir_change_d = (pend_dir_q != cur_dir_q);
            end else begin
              moving_d = open_mask[cur_dir_q];
              if (pend_valid_q) begin
                if (pend_cnt_q <= CNT_W'(1)) pend_valid_d = 1'b0;
                else                         pend_cnt_d   = pend_cnt_q - CNT_W'(1);
              end
            end
          end
          if (dir_press_c) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = dir_req_c;
            pend_cnt_d   = CNT_W'(PEND_TICKS);
          end
        end
      end

      ST_PAUSE: begin
        moving_d = 1'b0;
        if (center_press_c) state_d = ST_RUN;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cur_dir    = cur_dir_q;
  assign moving     = moving_q;
  assign pend_valid = pend_valid_q;
  assign pend_dir   = pend_dir_q;
  assign state      = state_q;
  assign dir_change = dir_change_q;

endmodule

// File: tb/tb_input_dir_ctrl.sv
// Directed testbench for input_dir_ctrl with hand-computed expected values.
module tb_input_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btns;
  logic       move_tick;
  logic [3:0] open_mask;
  logic [1:0] cur_dir;
  logic       moving;
  logic       pend_valid;
  logic [1:0] pend_dir;
  logic [1:0] state;
  logic       dir_change;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  input_dir_ctrl #(.SYNC_STAGES(2), .PEND_TICKS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btns[0]),
    .btn_down   (btns[1]),
    .btn_left   (btns[2]),
    .btn_right  (btns[3]),
    .btn_center (btns[4]),
    .move_tick  (move_tick),
    .open_mask  (open_mask),
    .cur_dir    (cur_dir),
    .moving     (moving),
    .pend_valid (pend_valid),
    .pend_dir   (pend_dir),
    .state      (state),
    .dir_change (dir_change)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raise a set of buttons, wait sync + history latency, then release
  task automatic press(input logic [4:0] mask);
    btns = mask;
    repeat (3) cyc();
    btns = '0;
  endtask

  task automatic do_tick();
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    btns      = 5'b00001;
    move_tick = 1'b0;
    open_mask = 4'b0000;
    repeat (3) cyc();

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cur_dir", 32'(cur_dir), 32'd2);
    chk("rst_moving", 32'(moving), 32'd0);
    chk("rst_pend_valid", 32'(pend_valid), 32'd0);
    chk("rst_pend_dir", 32'(pend_dir), 32'd0);
    chk("rst_dir_change", 32'(dir_change), 32'd0);

    // Button held through reset release must not register a press
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("held_dir_change", 32'(dir_change), 32'd0);
    end
    chk("held_state", 32'(state), 32'd0);
    chk("held_pend_valid", 32'(pend_valid), 32'd0);
    btns = '0;
    repeat (4) cyc();

    // IDLE right press: RUN after 3 cycles, then turn commit
    btns = 5'b01000;
    cyc();
    cyc();
    chk("lat_state_early", 32'(state), 32'd0);
    cyc();
    btns = '0;
    chk("idle_right_state", 32'(state), 32'd1);
    chk("idle_right_pvalid", 32'(pend_valid), 32'd1);
    chk("idle_right_pdir", 32'(pend_dir), 32'd3);
    open_mask = 4'b1000;
    do_tick();
    chk("commit_cur_dir", 32'(cur_dir), 32'd3);
    chk("commit_moving", 32'(moving), 32'd1);
    chk("commit_dir_change", 32'(dir_change), 32'd1);
    chk("commit_pvalid", 32'(pend_valid), 32'd0);
    cyc();
    chk("commit_pulse_end", 32'(dir_change), 32'd0);

    // Turn back to left to set up the blocked-request case
    press(5'b00100);
    open_mask = 4'b0100;
    do_tick();
    chk("left_cur_dir", 32'(cur_dir), 32'd2);
    chk("left_dir_change", 32'(dir_change), 32'd1);

    // Up blocked for 8 ticks: request expires on the 8th
    press(5'b00001);
    chk("up_pvalid", 32'(pend_valid), 32'd1);
    chk("up_pdir", 32'(pend_dir), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      chk("blk_moving", 32'(moving), 32'd1);
      chk("blk_cur_dir", 32'(cur_dir), 32'd2);
      chk("blk_pvalid", 32'(pend_valid), (k < 8) ? 32'd1 : 32'd0);
      chk("blk_dir_change", 32'(dir_change), 32'd0);
      cyc();
    end

    // Simultaneous down + left: down wins
    press(5'b00110);
    chk("prio_pvalid", 32'(pend_valid), 32'd1);
    chk("prio_pdir", 32'(pend_dir), 32'd1);

    // Tick and right press in the same cycle: tick commits down, press loads right
    btns = 5'b01000;
    cyc();
    cyc();
    open_mask = 4'b0010;
    move_tick = 1'b1;
    cyc();
    move_tick = 1'b0;
    btns = '0;
    chk("same_cur_dir", 32'(cur_dir), 32'd1);
    chk("same_dir_change", 32'(dir_change), 32'd1);
    chk("same_pvalid", 32'(pend_valid), 32'd1);
    chk("same_pdir", 32'(pend_dir), 32'd3);

    // Commit right, then pause behaviour
    open_mask = 4'b1000;
    do_tick();
    chk("r_cur_dir", 32'(cur_dir), 32'd3);
    chk("r_pvalid", 32'(pend_valid), 32'd0);
    press(5'b10000);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_moving", 32'(moving), 32'd0);
    press(5'b00001);
    chk("pause_ign_pvalid", 32'(pend_valid), 32'd0);
    chk("pause_ign_state", 32'(state), 32'd2);
    open_mask = 4'b1111;
    do_tick();
    cyc();
    do_tick();
    chk("pause_tick_moving", 32'(moving), 32'd0);
    chk("pause_tick_cur_dir", 32'(cur_dir), 32'd3);
    press(5'b10000);
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_pvalid", 32'(pend_valid), 32'd0);
    chk("resume_moving", 32'(moving), 32'd0);

    // Pending up, then reset pulsed during a tick
    press(5'b00001);
    chk("pre_rst_pvalid", 32'(pend_valid), 32'd1);
    move_tick = 1'b1;
    rst = 1'b1;
    #2;
    chk("async_state", 32'(state), 32'd0);
    chk("async_cur_dir", 32'(cur_dir), 32'd2);
    chk("async_moving", 32'(moving), 32'd0);
    chk("async_pvalid", 32'(pend_valid), 32'd0);
    chk("async_pdir", 32'(pend_dir), 32'd0);
    chk("async_dir_change", 32'(dir_change), 32'd0);
    cyc();
    rst = 1'b0;
    move_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("post_rst_dir_change", 32'(dir_change), 32'd0);
    end
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_pvalid", 32'(pend_valid), 32'd0);
    chk("post_rst_cur_dir", 32'(cur_dir), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
